// File: rtl/cmd_proc_if.sv
`default_nettype none
// ============================================================================
// Module      : cmd_proc_if
// Description : Signal bundle between cmd_proc, the UART command wrapper, the
//               gyro integrator, the IR sensors and the PID/fanfare/tour units.
// Revision    : 1.0
// ============================================================================
interface cmd_proc_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        strt_cal;
    logic        cal_done;
    logic [11:0] heading;
    logic        heading_rdy;
    logic        lftIR;
    logic        cntrIR;
    logic        rghtIR;
    logic        moving;
    logic [11:0] error;
    logic [9:0]  frwrd;
    logic        fanfare_go;
    logic        tour_go;

    modport master (
        output cmd, cmd_rdy, cal_done, heading, heading_rdy, lftIR, cntrIR, rghtIR,
        input  clr_cmd_rdy, send_resp, strt_cal, moving, error, frwrd, fanfare_go, tour_go
    );

    modport slave (
        input  cmd, cmd_rdy, cal_done, heading, heading_rdy, lftIR, cntrIR, rghtIR,
        output clr_cmd_rdy, send_resp, strt_cal, moving, error, frwrd, fanfare_go, tour_go
    );
endinterface
`default_nettype wire

// File: rtl/cmd_proc.sv
`default_nettype none
// ============================================================================
// Module      : cmd_proc
// Description : Knight's Tour command sequencer: calibration, heading settle,
//               forward-speed ramping and board-line counting for moves.
// Revision    : 1.0
// ============================================================================
module cmd_proc #(
    parameter bit         FAST_SIM  = 1'b1,
    parameter logic [9:0] MAX_FRWRD = 10'h300
) (
    input  logic       clk,
    input  logic       rst_n,
    cmd_proc_if.slave  bus
);

    localparam logic [2:0]  c_IDLE     = 3'd0;
    localparam logic [2:0]  c_CAL      = 3'd1;
    localparam logic [2:0]  c_WAIT_HDG = 3'd2;
    localparam logic [2:0]  c_RAMP_UP  = 3'd3;
    localparam logic [2:0]  c_RAMP_DN  = 3'd4;

    localparam logic [3:0]  c_OP_CAL   = 4'h2;
    localparam logic [3:0]  c_OP_MOVE  = 4'h4;
    localparam logic [3:0]  c_OP_FAN   = 4'h5;
    localparam logic [3:0]  c_OP_TOUR  = 4'h6;

    localparam logic [9:0]  c_FRWRD_INC = FAST_SIM ? 10'h020 : 10'h004;
    localparam logic [9:0]  c_FRWRD_DEC = FAST_SIM ? 10'h040 : 10'h008;
    localparam logic [11:0] c_NUDGE     = 12'h05F;
    localparam logic [11:0] c_SETTLE    = 12'h030;

    logic [2:0]  r_state;
    logic [11:0] r_desired_hdg;
    logic [3:0]  r_target;
    logic        r_fanfare;
    logic [3:0]  r_line_cnt;
    logic        r_cntr_prev;
    logic [9:0]  r_frwrd;
    logic        r_clr_cmd_rdy;
    logic        r_send_resp;
    logic        r_strt_cal;
    logic        r_fanfare_go;
    logic        r_tour_go;

    logic        w_moving;
    logic [11:0] w_nudge;
    logic [11:0] w_error;
    logic [11:0] w_abs_err;
    logic        w_settled;
    logic [10:0] w_frwrd_sum;
    logic [9:0]  w_frwrd_up;
    logic [9:0]  w_frwrd_dn;
    logic        w_cntr_rise;
    logic [3:0]  w_opcode;
    logic        w_unused_cmd_bit;

    assign w_opcode         = bus.cmd[15:12];
    assign w_unused_cmd_bit = bus.cmd[3];

    assign w_moving = (r_state == c_WAIT_HDG) || (r_state == c_RAMP_UP) ||
                      (r_state == c_RAMP_DN);

    // Guard-rail nudge steers away from whichever rail is seen; both rails cancel.
    always_comb begin
        w_nudge = 12'h000;
        if (w_moving && bus.lftIR && !bus.rghtIR)
            w_nudge = c_NUDGE;
        else if (w_moving && bus.rghtIR && !bus.lftIR)
            w_nudge = 12'h000 - c_NUDGE;
    end

    assign w_error   = bus.heading - r_desired_hdg + w_nudge;
    assign w_abs_err = w_error[11] ? (12'h000 - w_error) : w_error;
    assign w_settled = (w_abs_err < c_SETTLE);

    assign w_frwrd_sum = {1'b0, r_frwrd} + {1'b0, c_FRWRD_INC};
    assign w_frwrd_up  = (w_frwrd_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : w_frwrd_sum[9:0];
    assign w_frwrd_dn  = (r_frwrd < c_FRWRD_DEC) ? 10'h000 : (r_frwrd - c_FRWRD_DEC);

    assign w_cntr_rise = bus.cntrIR && !r_cntr_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_desired_hdg <= 12'h000;
            r_target      <= 4'h0;
            r_fanfare     <= 1'b0;
            r_line_cnt    <= 4'h0;
            r_cntr_prev   <= 1'b0;
            r_frwrd       <= 10'h000;
            r_clr_cmd_rdy <= 1'b0;
            r_send_resp   <= 1'b0;
            r_strt_cal    <= 1'b0;
            r_fanfare_go  <= 1'b0;
            r_tour_go     <= 1'b0;
        end else begin
            r_clr_cmd_rdy <= 1'b0;
            r_send_resp   <= 1'b0;
            r_strt_cal    <= 1'b0;
            r_fanfare_go  <= 1'b0;
            r_tour_go     <= 1'b0;
            r_cntr_prev   <= bus.cntrIR;

            if (w_moving && w_cntr_rise && (r_line_cnt != 4'hF))
                r_line_cnt <= r_line_cnt + 4'h1;

            case (r_state)
                c_IDLE: begin
                    if (bus.cmd_rdy) begin
                        r_clr_cmd_rdy <= 1'b1;
                        r_line_cnt    <= 4'h0;
                        case (w_opcode)
                            c_OP_CAL: begin
                                r_strt_cal <= 1'b1;
                                r_state    <= c_CAL;
                            end
                            c_OP_MOVE, c_OP_FAN: begin
                                r_desired_hdg <= (bus.cmd[11:4] == 8'h00) ? 12'h000
                                                 : {bus.cmd[11:4], 4'hF};
                                r_target      <= {bus.cmd[2:0], 1'b0};
                                r_fanfare     <= (w_opcode == c_OP_FAN);
                                r_state       <= c_WAIT_HDG;
                            end
                            c_OP_TOUR: r_tour_go <= 1'b1;
                            default:   r_state   <= c_IDLE;
                        endcase
                    end
                end
                c_CAL: begin
                    if (bus.cal_done) begin
                        r_send_resp <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                c_WAIT_HDG: begin
                    r_frwrd <= 10'h000;
                    if (w_settled)
                        r_state <= c_RAMP_UP;
                end
                c_RAMP_UP: begin
                    // Target check wins so squares=0 leaves with frwrd still 0.
                    if (r_line_cnt == r_target)
                        r_state <= c_RAMP_DN;
                    else if (bus.heading_rdy)
                        r_frwrd <= w_frwrd_up;
                end
                c_RAMP_DN: begin
                    if (r_frwrd == 10'h000) begin
                        r_send_resp  <= 1'b1;
                        r_fanfare_go <= r_fanfare;
                        r_state      <= c_IDLE;
                    end else if (bus.heading_rdy) begin
                        r_frwrd <= w_frwrd_dn;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.clr_cmd_rdy = r_clr_cmd_rdy;
    assign bus.send_resp   = r_send_resp;
    assign bus.strt_cal    = r_strt_cal;
    assign bus.fanfare_go  = r_fanfare_go;
    assign bus.tour_go     = r_tour_go;
    assign bus.moving      = w_moving;
    assign bus.error       = w_error;
    assign bus.frwrd       = r_frwrd;

endmodule
`default_nettype wire

// File: tb/tb_cmd_proc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_proc
// Description : Directed, table-driven bench for cmd_proc (FAST_SIM=1).
// Revision    : 1.0
// ============================================================================
module tb_cmd_proc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_proc_if bus ();

    cmd_proc #(.FAST_SIM(1'b1), .MAX_FRWRD(10'h300)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [11:0] hdg;
        logic        lft;
        logic        rght;
        logic [11:0] exp_err;
        logic        exp_moving;
        logic [9:0]  exp_frwrd;
    } err_vec_t;

    err_vec_t vecs [9];

    int n_vec = 0;
    int n_err = 0;
    int resp_cnt = 0;
    int fan_cnt  = 0;
    int both_cnt = 0;
    int base_resp, base_fan, base_both;

    always @(negedge clk) begin
        if (bus.send_resp) resp_cnt++;
        if (bus.fanfare_go) fan_cnt++;
        if (bus.send_resp && bus.fanfare_go) both_cnt++;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [15:0] c);
        bus.cmd     = c;
        bus.cmd_rdy = 1'b1;
        tick();
        bus.cmd_rdy = 1'b0;
    endtask

    task automatic hrdy();
        bus.heading_rdy = 1'b1;
        tick();
        bus.heading_rdy = 1'b0;
    endtask

    task automatic line_pulse();
        bus.cntrIR = 1'b1;
        tick();
        bus.cntrIR = 1'b0;
        tick();
    endtask

    task automatic mark();
        base_resp = resp_cnt;
        base_fan  = fan_cnt;
        base_both = both_cnt;
    endtask

    initial begin
        // Heading-error vectors while a move to desired 12'h3FF waits for settle.
        vecs[0] = '{12'h000, 1'b0, 1'b0, 12'hC01, 1'b1, 10'h000};
        vecs[1] = '{12'h000, 1'b1, 1'b0, 12'hC60, 1'b1, 10'h000};
        vecs[2] = '{12'h000, 1'b0, 1'b1, 12'hBA2, 1'b1, 10'h000};
        vecs[3] = '{12'h000, 1'b1, 1'b1, 12'hC01, 1'b1, 10'h000};
        vecs[4] = '{12'h42F, 1'b0, 1'b0, 12'h030, 1'b1, 10'h000};
        vecs[5] = '{12'h3CF, 1'b0, 1'b0, 12'hFD0, 1'b1, 10'h000};
        vecs[6] = '{12'h800, 1'b1, 1'b0, 12'h460, 1'b1, 10'h000};
        vecs[7] = '{12'hFFF, 1'b0, 1'b1, 12'hBA1, 1'b1, 10'h000};
        vecs[8] = '{12'h42E, 1'b0, 1'b0, 12'h02F, 1'b1, 10'h000};

        bus.cmd = 16'h0000; bus.cmd_rdy = 1'b0; bus.cal_done = 1'b0;
        bus.heading = 12'h000; bus.heading_rdy = 1'b0;
        bus.lftIR = 1'b0; bus.cntrIR = 1'b0; bus.rghtIR = 1'b0;

        // Reset state
        tick(2);
        check("rst_frwrd",   {6'd0, bus.frwrd}, 16'h0000);
        check("rst_moving",  {15'd0, bus.moving}, 16'h0000);
        check("rst_error",   {4'd0, bus.error}, 16'h0000);
        check("rst_pulses",  {11'd0, bus.clr_cmd_rdy, bus.send_resp, bus.strt_cal,
                              bus.fanfare_go, bus.tour_go}, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Calibration command
        mark();
        issue(16'h2000);
        check("cal_clr",     {15'd0, bus.clr_cmd_rdy}, 16'h0001);
        check("cal_strt",    {15'd0, bus.strt_cal}, 16'h0001);
        check("cal_tour",    {15'd0, bus.tour_go}, 16'h0000);
        tick();
        check("cal_strt_1cy", {15'd0, bus.strt_cal}, 16'h0000);
        bus.cmd = 16'h6000; bus.cmd_rdy = 1'b1;
        tick();
        bus.cmd_rdy = 1'b0;
        check("busy_no_clr",  {15'd0, bus.clr_cmd_rdy}, 16'h0000);
        check("busy_no_tour", {15'd0, bus.tour_go}, 16'h0000);
        tick(98);
        check("cal_wait_resp",   16'(resp_cnt - base_resp), 16'h0000);
        check("cal_wait_moving", {15'd0, bus.moving}, 16'h0000);
        bus.cal_done = 1'b1;
        tick();
        bus.cal_done = 1'b0;
        check("cal_resp_now", {15'd0, bus.send_resp}, 16'h0001);
        tick(3);
        check("cal_resp_cnt", 16'(resp_cnt - base_resp), 16'h0001);
        check("cal_moving",   {15'd0, bus.moving}, 16'h0000);

        // Tour and unknown commands
        mark();
        issue(16'h6000);
        check("tour_clr", {15'd0, bus.clr_cmd_rdy}, 16'h0001);
        check("tour_go",  {15'd0, bus.tour_go}, 16'h0001);
        tick();
        check("tour_go_1cy", {15'd0, bus.tour_go}, 16'h0000);
        issue(16'hF000);
        check("unk_clr",  {15'd0, bus.clr_cmd_rdy}, 16'h0001);
        check("unk_misc", {13'd0, bus.tour_go, bus.strt_cal, bus.moving}, 16'h0000);
        tick(3);
        check("tour_unk_resp", 16'(resp_cnt - base_resp), 16'h0000);

        // Fanfare move: settle table, ramp, four lines mid-ramp, ramp down
        mark();
        issue(16'h53F2);
        check("fan_clr", {15'd0, bus.clr_cmd_rdy}, 16'h0001);
        for (int i = 0; i < 9; i++) begin
            bus.heading = vecs[i].hdg;
            bus.lftIR   = vecs[i].lft;
            bus.rghtIR  = vecs[i].rght;
            bus.heading_rdy = 1'b1;
            #1;
            check($sformatf("vec%0d_error", i),  {4'd0, bus.error}, {4'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_moving", i), {15'd0, bus.moving}, {15'd0, vecs[i].exp_moving});
            check($sformatf("vec%0d_frwrd", i),  {6'd0, bus.frwrd}, {6'd0, vecs[i].exp_frwrd});
            tick();
        end
        bus.heading_rdy = 1'b0;
        bus.lftIR = 1'b0; bus.rghtIR = 1'b0;
        bus.heading = 12'h3FF;
        hrdy(); check("fan_up1", {6'd0, bus.frwrd}, 16'h0020);
        hrdy(); check("fan_up2", {6'd0, bus.frwrd}, 16'h0040);
        hrdy(); check("fan_up3", {6'd0, bus.frwrd}, 16'h0060);
        repeat (4) line_pulse();
        check("fan_hold", {6'd0, bus.frwrd}, 16'h0060);
        hrdy(); check("fan_dn1", {6'd0, bus.frwrd}, 16'h0020);
        hrdy(); check("fan_dn2", {6'd0, bus.frwrd}, 16'h0000);
        check("fan_resp_not_yet", {15'd0, bus.send_resp}, 16'h0000);
        tick();
        check("fan_resp_now", {14'd0, bus.send_resp, bus.fanfare_go}, 16'h0003);
        check("fan_idle",     {15'd0, bus.moving}, 16'h0000);
        tick(2);
        check("fan_resp_cnt", 16'(resp_cnt - base_resp), 16'h0001);
        check("fan_go_cnt",   16'(fan_cnt - base_fan), 16'h0001);
        check("fan_both_cnt", 16'(both_cnt - base_both), 16'h0001);

        // Plain move: saturation, guard-rail nudges, full ramp down
        mark();
        bus.heading = 12'h000;
        issue(16'h4001);
        check("mv_wait", {5'd0, bus.moving, bus.frwrd}, 16'h0400);
        tick();
        hrdy(); check("mv_up1", {6'd0, bus.frwrd}, 16'h0020);
        hrdy(); check("mv_up2", {6'd0, bus.frwrd}, 16'h0040);
        repeat (38) hrdy();
        check("mv_sat", {6'd0, bus.frwrd}, 16'h0300);
        bus.lftIR = 1'b1; #1;
        check("mv_lft_nudge", {4'd0, bus.error}, 16'h005F);
        bus.lftIR = 1'b0; bus.rghtIR = 1'b1; #1;
        check("mv_rght_nudge", {4'd0, bus.error}, 16'h0FA1);
        bus.rghtIR = 1'b0;
        repeat (2) line_pulse();
        check("mv_hold", {6'd0, bus.frwrd}, 16'h0300);
        hrdy(); check("mv_dn1", {6'd0, bus.frwrd}, 16'h02C0);
        repeat (11) hrdy();
        check("mv_dn_end", {6'd0, bus.frwrd}, 16'h0000);
        tick();
        check("mv_resp_now", {14'd0, bus.send_resp, bus.fanfare_go}, 16'h0002);
        tick(2);
        check("mv_resp_cnt", 16'(resp_cnt - base_resp), 16'h0001);
        check("mv_fan_cnt",  16'(fan_cnt - base_fan), 16'h0000);

        // Reset during RAMP_UP
        mark();
        issue(16'h4003);
        tick();
        hrdy(); hrdy();
        check("rr_pre", {6'd0, bus.frwrd}, 16'h0040);
        rst_n = 1'b0; #1;
        check("rr_frwrd",  {6'd0, bus.frwrd}, 16'h0000);
        check("rr_moving", {15'd0, bus.moving}, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick(3);
        check("rr_no_resp", 16'(resp_cnt - base_resp), 16'h0000);
        check("rr_idle",    {5'd0, bus.moving, bus.frwrd}, 16'h0000);

        // squares=0 move after reset: response two cycles after RAMP_UP entry
        mark();
        issue(16'h4000);
        check("z_clr",    {14'd0, bus.clr_cmd_rdy, bus.moving}, 16'h0003);
        check("z_resp0",  {15'd0, bus.send_resp}, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("z_resp_c%0d", k),   {15'd0, bus.send_resp}, (k == 2) ? 16'h0001 : 16'h0000);
            check($sformatf("z_moving_c%0d", k), {15'd0, bus.moving},    (k < 2)  ? 16'h0001 : 16'h0000);
        end
        check("z_resp_cnt", 16'(resp_cnt - base_resp), 16'h0001);
        check("z_frwrd",    {6'd0, bus.frwrd}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_proc.md
# cmd_proc

Command sequencer between the UART command wrapper and the motion datapath of the Knight's Tour robot. Decodes 16-bit remote commands, starts and waits on gyro calibration, and runs move commands. A move sets the desired heading, waits for heading settle, ramps forward speed up, counts board lines on the centre IR sensor, ramps speed down and acknowledges. The block drives the PID (`error`, `frwrd`, `moving`), the NEMO integrator (`strt_cal`), the response path (`send_resp`) and the fanfare/tour units.

## Interface
Parameters:
- FAST_SIM, 1, selects speed step: 1 → FRWRD_INC = 10'h020; 0 → FRWRD_INC = 10'h004
- MAX_FRWRD, 10'h300, forward-speed saturation value

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  16  command word; [15:12] opcode, [11:4] heading, [2:0] squares
- cmd_rdy  in  1  command valid from UART wrapper
- clr_cmd_rdy  out  1  one-cycle pulse, command consumed
- send_resp  out  1  one-cycle pulse, send positive ack (0xA5)
- strt_cal  out  1  one-cycle pulse, start gyro calibration
- cal_done  in  1  calibration complete from integrator
- heading  in  12  signed current heading from integrator
- heading_rdy  in  1  new heading valid, once per gyro sample
- lftIR, cntrIR, rghtIR  in  1 each  IR line/guard-rail sensors, active high
- moving  out  1  motion in progress; enables PID integrator
- error  out  12  signed heading error to PID
- frwrd  out  10  unsigned forward speed to PID
- fanfare_go  out  1  one-cycle pulse at end of fanfare move
- tour_go  out  1  one-cycle pulse, hand control to tour logic

## Operation
- States: IDLE, CAL, WAIT_HDG, RAMP_UP, RAMP_DN.
- IDLE, cmd_rdy=1: latch cmd, pulse clr_cmd_rdy, clear line counter, decode opcode:
  - 4'h2 → pulse strt_cal, go CAL.
  - 4'h4 / 4'h5 → latch desired heading (cmd[11:4]==0 ? 12'h000 : {cmd[11:4],4'hF}), target = 2×cmd[2:0] (4 bits), fanfare flag = opcode==5, go WAIT_HDG.
  - 4'h6 → pulse tour_go, stay IDLE, no response.
  - other → stay IDLE, no response.
- CAL: on cal_done pulse send_resp, go IDLE.
- WAIT_HDG: frwrd held 0; when signed |error| < 12'h030 go RAMP_UP.
- RAMP_UP: each heading_rdy, frwrd += FRWRD_INC, saturating at MAX_FRWRD. When line count == target, go RAMP_DN.
- RAMP_DN: each heading_rdy, frwrd -= 2×FRWRD_INC, floor 0. In the cycle frwrd==0, pulse send_resp, pulse fanfare_go if flag set, go IDLE.
- moving=1 in WAIT_HDG, RAMP_UP, RAMP_DN; else 0.
- error = heading − desired_heading, 12-bit wrap. When moving: lftIR adds +12'h05F; rghtIR adds −12'h05F; both asserted → no nudge.
- Line counter: 4 bits. Increments on cntrIR rising edge (registered previous value) while moving, saturates at 15.
- cmd_rdy in a non-IDLE state is ignored; clr_cmd_rdy is not asserted.

## Timing
- Reset: state IDLE; frwrd=0, counter=0, cntrIR history=0, desired heading=0. All pulse outputs and moving are 0.
- error is combinational from registered desired heading and input heading.
- clr_cmd_rdy, strt_cal and tour_go are asserted in the cycle after the cmd_rdy sample.
- send_resp is asserted in the cycle after cal_done is sampled.
- Move response is asserted one cycle after frwrd reaches 0 in RAMP_DN. fanfare_go is asserted in the same cycle.
- squares=0: RAMP_UP exits on entry with frwrd=0, so send_resp follows two cycles after RAMP_UP entry.
- Target is reached mid-ramp-up: deceleration starts from the current frwrd.
- rst_n deasserted mid-move: immediate return to reset values, and no response.

## Test plan
- cmd 16'h2000 → clr_cmd_rdy pulse, strt_cal pulse; cal_done after 100 cycles → exactly one send_resp, moving stays 0.
- cmd 16'h4001, heading=12'h000 → WAIT_HDG, frwrd 0x000→0x020→… per heading_rdy. Two cntrIR rising edges → ramp down by 0x040 steps → frwrd=0 → one send_resp, no fanfare_go.
- cmd 16'h53F2, heading 12'h3FF → ramp held until heading within 0x30 of 12'h3FF. Four lines → send_resp and fanfare_go together.
- Ramp with no lines for 40 heading_rdy → frwrd saturates at 10'h300. lftIR=1 → error increases by 0x05F.
- cmd 16'h6000 → tour_go pulse, no send_resp. cmd 16'hF000 → clr_cmd_rdy only.
- Reset asserted during RAMP_UP → frwrd=0, moving=0, state IDLE. A new 16'h4000 command runs normally.
